// File: rtl/mont_word_mm.sv
// rtl/mont_word_mm.sv - word-serial Montgomery multiplier with final subtraction
//
// Computes R = X*Y*2^(-K*N) mod P. Operands are preloaded word by word into
// internal register files; the result is streamed out LSW first.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ld_en/ld_sel/ld_addr/ld_data
//                        operand word write (sel 0=X, 1=Y, 2=P, 3=dropped),
//                        ignored while busy
//   p1                   -P^-1 mod 2^K, sampled when start is accepted
//   start                begin operation (accepted only when not busy)
//   busy                 operation in progress
//   res_valid/res_ready/res_data/res_last
//                        result word stream, LSW first, last marks word N-1
//   done                 one-cycle pulse after the final word is accepted
`timescale 1ns/1ps
module mont_word_mm #(
    parameter int K      = 64,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [1:0]        ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [K-1:0]      ld_data,
    input  logic [K-1:0]      p1,
    input  logic              start,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [K-1:0]      res_data,
    output logic              res_last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    // MUL is split into its Q, J and TOP sub-phases.
    typedef enum logic [2:0] {
        S_IDLE, S_MQ, S_MJ, S_MTOP, S_SUB, S_OUT
    } state_t;

    state_t            state;
    logic [K-1:0]      xm [N];
    logic [K-1:0]      ym [N];
    logic [K-1:0]      pm [N];
    logic [K-1:0]      a  [N];
    logic              a_top;
    logic [K+1:0]      carry;
    logic [K-1:0]      q;
    logic [K-1:0]      p1_r;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic              bor;
    logic              ge;

    // Operand register files: not reset, writes dropped while an op runs.
    always_ff @(posedge clk) begin
        if (ld_en && !busy) begin
            case (ld_sel)
                2'd0:    xm[ld_addr] <= ld_data;
                2'd1:    ym[ld_addr] <= ld_data;
                2'd2:    pm[ld_addr] <= ld_data;
                default: ;
            endcase
        end
    end

    logic [K-1:0]     xi;
    logic [2*K-1:0]   xy;
    logic [2*K-1:0]   qp;
    logic [K-1:0]     q_in;
    logic [K-1:0]     q_next;
    logic [2*K+1:0]   sum;
    logic [K:0]       top_t;
    logic [K-1:0]     sub_p;
    logic [K:0]       sub_d;

    assign xi     = xm[i];
    // j is 0 during the Q cycle, so xy there is X[i]*Y[0].
    assign xy     = {{K{1'b0}}, xi} * {{K{1'b0}}, ym[j]};
    assign qp     = {{K{1'b0}}, q} * {{K{1'b0}}, pm[j]};
    assign q_in   = a[0] + xy[K-1:0];
    assign q_next = q_in * p1_r;
    assign sum    = {2'b00, xy} + {2'b00, qp}
                  + {{(K+2){1'b0}}, a[j]} + {{K{1'b0}}, carry};
    assign top_t  = carry[K:0] + {{K{1'b0}}, a_top};
    // SUB always compares against P; OUT subtracts P only if A >= P.
    assign sub_p  = (state == S_SUB || ge) ? pm[j] : '0;
    assign sub_d  = {1'b0, a[j]} - {1'b0, sub_p} - {{K{1'b0}}, bor};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
            done      <= 1'b0;
            for (int k = 0; k < N; k++) a[k] <= '0;
            a_top     <= 1'b0;
            carry     <= '0;
            q         <= '0;
            p1_r      <= '0;
            i         <= '0;
            j         <= '0;
            bor       <= 1'b0;
            ge        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p1_r  <= p1;
                        for (int k = 0; k < N; k++) a[k] <= '0;
                        a_top <= 1'b0;
                        carry <= '0;
                        i     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        state <= S_MQ;
                    end
                end
                S_MQ: begin
                    q     <= q_next;
                    state <= S_MJ;
                end
                S_MJ: begin
                    // Word 0 of the sum is zero by choice of q; the rest
                    // shift down one word.
                    carry <= sum[2*K+1:K];
                    if (j != '0) a[j - 1'b1] <= sum[K-1:0];
                    if (j == LAST) begin
                        j     <= '0;
                        state <= S_MTOP;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_MTOP: begin
                    a[N-1] <= top_t[K-1:0];
                    a_top  <= top_t[K];
                    carry  <= '0;
                    if (i == LAST) begin
                        i     <= '0;
                        bor   <= 1'b0;
                        state <= S_SUB;
                    end else begin
                        i     <= i + 1'b1;
                        state <= S_MQ;
                    end
                end
                S_SUB: begin
                    if (j == LAST) begin
                        ge    <= a_top | ~sub_d[K];
                        bor   <= 1'b0;
                        j     <= '0;
                        state <= S_OUT;
                    end else begin
                        bor <= sub_d[K];
                        j   <= j + 1'b1;
                    end
                end
                S_OUT: begin
                    // bor/j hold the borrow and index of the next word to
                    // present; they only advance when a word is loaded.
                    if (!res_valid || res_ready) begin
                        if (res_valid && res_last) begin
                            res_valid <= 1'b0;
                            res_last  <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            res_data  <= sub_d[K-1:0];
                            bor       <= sub_d[K];
                            res_valid <= 1'b1;
                            res_last  <= (j == LAST);
                            j         <= (j == LAST) ? '0 : j + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_word_mm.sv
// tb/tb_mont_word_mm.sv - self-checking bench for mont_word_mm
`timescale 1ns/1ps
module tb_mont_word_mm;

    localparam int SK = 8;
    localparam int SN = 2;
    localparam int BK = 64;
    localparam int BN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          s_ld_en, s_start, s_busy, s_res_valid, s_res_ready, s_res_last, s_done;
    logic [1:0]    s_ld_sel;
    logic [0:0]    s_ld_addr;
    logic [SK-1:0] s_ld_data, s_p1, s_res_data;

    logic          b_ld_en, b_start, b_busy, b_res_valid, b_res_ready, b_res_last, b_done;
    logic [1:0]    b_ld_sel;
    logic [3:0]    b_ld_addr;
    logic [BK-1:0] b_ld_data, b_p1, b_res_data;

    mont_word_mm #(.K(SK), .N(SN)) dut_s (
        .clk(clk), .rst_n(rst_n), .ld_en(s_ld_en), .ld_sel(s_ld_sel), .ld_addr(s_ld_addr),
        .ld_data(s_ld_data), .p1(s_p1), .start(s_start), .busy(s_busy), .res_valid(s_res_valid),
        .res_ready(s_res_ready), .res_data(s_res_data), .res_last(s_res_last), .done(s_done));

    mont_word_mm #(.K(BK), .N(BN)) dut_b (
        .clk(clk), .rst_n(rst_n), .ld_en(b_ld_en), .ld_sel(b_ld_sel), .ld_addr(b_ld_addr),
        .ld_data(b_ld_data), .p1(b_p1), .start(b_start), .busy(b_busy), .res_valid(b_res_valid),
        .res_ready(b_res_ready), .res_data(b_res_data), .res_last(b_res_last), .done(b_done));

    int total = 0;
    int bad   = 0;
    int ge1   = 0;
    int ge0   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width Montgomery reduction with plain big-number arithmetic.
    function automatic logic [1023:0] ref_mm(input logic [1023:0] x, input logic [1023:0] y,
                                             input logic [1023:0] p, input int nb, output bit ge);
        logic [2111:0] msk, inv, pw, xy, m, t;
        msk = (2112'd1 << nb) - 2112'd1;
        pw  = {1088'd0, p};
        inv = 2112'd1;
        for (int k = 0; k < 11; k++) inv = (inv * (2112'd2 - pw * inv)) & msk;
        xy = {1088'd0, x} * {1088'd0, y};
        m  = ((xy & msk) * ((~inv + 2112'd1) & msk)) & msk;
        t  = (xy + m * pw) >> nb;
        ge = (t >= pw);
        if (ge) t = t - pw;
        return t[1023:0];
    endfunction

    function automatic logic [63:0] neg_inv(input logic [63:0] p0);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < 7; k++) v = v * (64'd2 - p0 * v);
        return -v;
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic s_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] p);
        logic [15:0] v;
        for (int s = 0; s < 3; s++) begin
            v = (s == 0) ? x : (s == 1) ? y : p;
            for (int w = 0; w < SN; w++) begin
                s_ld_en   = 1'b1;
                s_ld_sel  = 2'(s);
                s_ld_addr = 1'(w);
                s_ld_data = v[w*8 +: 8];
                tick();
            end
        end
        s_ld_en = 1'b0;
    endtask

    // Runs one op on the small instance. pat gives res_ready for the first
    // four valid cycles; st_cyc/ld_cyc inject a start / X write at that cycle.
    task automatic s_op(input string tag, input logic [3:0] pat, input int st_cyc,
                        input int ld_cyc, output logic [15:0] res, output int lat);
        int cyc, vc, nw, acc_cyc;
        bit prev_stall, fin;
        logic [7:0] prev_d;
        res = '0; lat = -1; vc = 0; nw = 0; acc_cyc = -10;
        prev_stall = 1'b0; fin = 1'b0; prev_d = '0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (cyc = 0; cyc < 300 && !fin; cyc++) begin
            s_start   = (cyc == st_cyc);
            s_ld_en   = (cyc == ld_cyc);
            s_ld_sel  = 2'd0;
            s_ld_addr = 1'b0;
            s_ld_data = 8'hAA;
            if (prev_stall) begin
                chk({tag, "_hold_data"}, 64'(s_res_data), 64'(prev_d));
                chk({tag, "_hold_valid"}, 64'(s_res_valid), 64'd1);
            end
            prev_stall = 1'b0;
            if (s_done) begin
                chk({tag, "_done_time"}, 64'(cyc), 64'(acc_cyc + 1));
                fin = 1'b1;
            end else begin
                if (s_res_valid) begin
                    if (lat < 0) lat = cyc;
                    s_res_ready = (vc < 4) ? pat[vc] : 1'b1;
                    vc++;
                    if (s_res_ready) begin
                        if (nw < SN) res[nw*8 +: 8] = s_res_data;
                        chk({tag, "_last"}, 64'(s_res_last), 64'(nw == SN - 1));
                        nw++;
                        acc_cyc = cyc;
                    end else begin
                        prev_stall = 1'b1;
                        prev_d     = s_res_data;
                    end
                end else begin
                    s_res_ready = 1'b1;
                end
                tick();
            end
        end
        s_start = 1'b0;
        s_ld_en = 1'b0;
        if (!fin) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            tick();
            chk({tag, "_done_pulse"}, 64'(s_done), 64'd0);
            chk({tag, "_busy_end"}, 64'(s_busy), 64'd0);
        end
        chk({tag, "_nwords"}, 64'(nw), 64'(SN));
    endtask

    task automatic b_run(input logic [1023:0] x, input logic [1023:0] y, input logic [1023:0] p,
                         input logic [63:0] p1v, output logic [1023:0] res, output int nw,
                         output bit fin);
        logic [1023:0] v;
        logic [63:0] prev_d;
        bit prev_stall;
        int cyc;
        for (int s = 0; s < 3; s++) begin
            v = (s == 0) ? x : (s == 1) ? y : p;
            for (int w = 0; w < BN; w++) begin
                b_ld_en   = 1'b1;
                b_ld_sel  = 2'(s);
                b_ld_addr = 4'(w);
                b_ld_data = v[w*64 +: 64];
                tick();
            end
        end
        b_ld_en = 1'b0;
        b_p1    = p1v;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        nw = 0; fin = 1'b0; res = '0; prev_stall = 1'b0; prev_d = '0;
        for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (prev_stall) chk("big_hold", b_res_data, prev_d);
            prev_stall = 1'b0;
            if (b_done) begin
                fin = 1'b1;
            end else begin
                if (b_res_valid) begin
                    b_res_ready = ($urandom_range(0, 3) != 0);
                    if (b_res_ready) begin
                        if (nw < BN) res[nw*64 +: 64] = b_res_data;
                        chk("big_last", 64'(b_res_last), 64'(nw == BN - 1));
                        nw++;
                    end else begin
                        prev_stall = 1'b1;
                        prev_d     = b_res_data;
                    end
                end else begin
                    b_res_ready = 1'b1;
                end
                tick();
            end
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] e;
    } vec_t;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        logic [15:0] res16, x16, y16, p16;
        logic [1023:0] bx, by, bp, bres, bexp;
        int lat, nw;
        bit fin, ge;

        tbl[0] = '{16'h1234, 16'h000F, 16'h1234};
        tbl[1] = '{16'hFFF0, 16'h00E1, 16'hFFE2};
        tbl[2] = '{16'h0000, 16'h5555, 16'h0000};
        tbl[3] = '{16'h000F, 16'h000F, 16'h000F};
        tbl[4] = '{16'h00E1, 16'h0001, 16'h000F};
        tbl[5] = '{16'h0001, 16'h00E1, 16'h000F};
        tbl[6] = '{16'hFFF0, 16'h000F, 16'hFFF0};
        tbl[7] = '{16'hFFF0, 16'hFFF0, 16'hEEE1};
        tbl[8] = '{16'h0001, 16'h0001, 16'hEEE1};

        rst_n = 1'b0;
        s_ld_en = 0; s_ld_sel = 0; s_ld_addr = 0; s_ld_data = 0; s_p1 = 0; s_start = 0; s_res_ready = 0;
        b_ld_en = 0; b_ld_sel = 0; b_ld_addr = 0; b_ld_data = 0; b_p1 = 0; b_start = 0; b_res_ready = 0;
        repeat (3) tick();
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_valid", 64'(s_res_valid), 64'd0);
        chk("rst_last", 64'(s_res_last), 64'd0);
        chk("rst_done", 64'(s_done), 64'd0);
        chk("rst_data", 64'(s_res_data), 64'd0);
        chk("rst_big_busy", 64'(b_busy), 64'd0);
        chk("rst_big_valid", 64'(b_res_valid), 64'd0);
        chk("rst_big_data", b_res_data, 64'd0);
        rst_n = 1'b1;
        tick();

        s_p1 = 8'hEF;
        for (int t = 0; t < 9; t++) begin
            s_load(tbl[t].x, tbl[t].y, 16'hFFF1);
            s_op("tbl", 4'hF, -1, -1, res16, lat);
            chk("tbl_result", 64'(res16), 64'(tbl[t].e));
            chk("tbl_latency", 64'(lat), 64'd11);
        end

        // back-to-back start with no reload
        s_load(16'h0000, 16'h5555, 16'hFFF1);
        s_op("b2b_a", 4'hF, -1, -1, res16, lat);
        chk("b2b_first", 64'(res16), 64'd0);
        s_op("b2b_b", 4'hF, -1, -1, res16, lat);
        chk("b2b_second", 64'(res16), 64'd0);

        // backpressure 1,0,0,1
        s_load(16'h1234, 16'h000F, 16'hFFF1);
        s_op("stall", 4'b1001, -1, -1, res16, lat);
        chk("stall_result", 64'(res16), 64'h1234);

        // start during MUL and X write during SUB are ignored
        s_op("intr", 4'hF, 3, 8, res16, lat);
        chk("intr_result", 64'(res16), 64'h1234);
        chk("intr_latency", 64'(lat), 64'd11);
        s_op("intr_rerun", 4'hF, -1, -1, res16, lat);
        chk("intr_x_kept", 64'(res16), 64'h1234);

        // asynchronous reset mid-MUL
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (3) tick();
        chk("mid_busy", 64'(s_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(s_busy), 64'd0);
        chk("arst_valid", 64'(s_res_valid), 64'd0);
        chk("arst_done", 64'(s_done), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        s_op("after_rst", 4'hF, -1, -1, res16, lat);
        chk("after_rst_result", 64'(res16), 64'h1234);

        // random small operands
        for (int v = 0; v < 100; v++) begin
            p16 = 16'($urandom()) | 16'h8001;
            x16 = 16'($urandom()) % p16;
            y16 = 16'($urandom()) % p16;
            if (v == 0) begin x16 = p16 - 16'd1; y16 = p16 - 16'd1; end
            s_p1 = neg_inv({48'd0, p16})[7:0];
            bexp = ref_mm({1008'd0, x16}, {1008'd0, y16}, {1008'd0, p16}, 16, ge);
            if (ge) ge1++; else ge0++;
            s_load(x16, y16, p16);
            s_op("srnd", 4'hF, -1, -1, res16, lat);
            chk("srnd_result", 64'(res16), bexp[63:0]);
        end

        // random full-size operands with random backpressure
        for (int v = 0; v < 40; v++) begin
            bp = rnd1024();
            bp[1023] = 1'b1;
            bp[0] = 1'b1;
            bx = rnd1024() % bp;
            by = rnd1024() % bp;
            if (v == 0) begin bx = bp - 1024'd1; by = bp - 1024'd1; end
            if (v == 1) begin bx = '0; end
            bexp = ref_mm(bx, by, bp, 1024, ge);
            if (ge) ge1++; else ge0++;
            b_run(bx, by, bp, neg_inv(bp[63:0]), bres, nw, fin);
            chk("big_finish", 64'(fin), 64'd1);
            chk("big_nwords", 64'(nw), 64'(BN));
            for (int w = 0; w < BN; w++) chk("big_word", bres[w*64 +: 64], bexp[w*64 +: 64]);
        end
        chk("ge1_seen", 64'(ge1 > 0), 64'd1);
        chk("ge0_seen", 64'(ge0 > 0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
